// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Gshare branch predictor with a direct-mapped branch target buffer.
// The fetch stage gets a zero-latency, purely combinational prediction for
// fetch_pc. The MEM stage resolves control instructions, which trains the BTB
// and the PHT. On a misprediction, or on a conditional branch that missed in
// the BTB, it also repairs the speculative global history register.
//
// Configuration macro:
//   BP_FWD_EN  - when defined, a same-cycle update is forwarded into the
//                lookup path. When undefined, the lookup sees registered
//                state only.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   fetch_pc          - lookup address; fetch_adv - fetch stage advances
//   pred_hit/uc/taken - BTB hit, unconditional entry, predicted taken
//   pred_target       - target field of the indexed BTB entry
//   pred_ghr          - speculative GHR at lookup (carried down the pipe)
//   upd_*             - resolution info for one control instruction in MEM
//   mispredict        - combinational mispredict flag for the update
//   mispredict_count  - saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         BTB_IDX_BITS = 3,
    parameter int         GHR_BITS     = 4,
    parameter logic [1:0] CTR_INIT     = 2'b01
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         fetch_pc,
    input  logic                fetch_adv,
    output logic                pred_hit,
    output logic                pred_uc,
    output logic                pred_taken,
    output logic [15:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [15:0]         upd_pc,
    input  logic                upd_cond,
    input  logic                upd_taken,
    input  logic [15:0]         upd_target,
    input  logic                upd_pred_hit,
    input  logic                upd_pred_taken,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic                mispredict,
    output logic [15:0]         mispredict_count
);

    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS    = 15 - BTB_IDX_BITS;
    localparam int PHT_ENTRIES = 1 << GHR_BITS;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
            else              res = ctr;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
            else              res = ctr;
        end
        return res;
    endfunction

    logic                    valid_r  [BTB_ENTRIES];
    logic                    uc_r     [BTB_ENTRIES];
    logic [TAG_BITS-1:0]     tag_r    [BTB_ENTRIES];
    logic [15:0]             target_r [BTB_ENTRIES];
    logic [1:0]              pht_r    [PHT_ENTRIES];
    logic [GHR_BITS-1:0]     ghr_r;
    logic [15:0]             count_r;

    logic [BTB_IDX_BITS-1:0] lk_idx_s;
    logic [TAG_BITS-1:0]     lk_tag_s;
    logic [GHR_BITS-1:0]     lk_pht_idx_s;
    logic [BTB_IDX_BITS-1:0] up_idx_s;
    logic [TAG_BITS-1:0]     up_tag_s;
    logic [GHR_BITS-1:0]     up_pht_idx_s;
    logic [1:0]              up_ctr_next_s;
    logic                    hit_s;
    logic                    uc_s;
    logic                    ctr_msb_s;
    logic [15:0]             target_s;
    logic                    repair_s;
    logic                    unused_ok_s;

    // PC bit 0 is always zero for word-aligned instructions and never indexes anything.
    assign unused_ok_s = fetch_pc[0] ^ upd_pc[0];

    // Index, tag and hash extraction for both the lookup and the update port.
    always_comb begin
        lk_idx_s      = fetch_pc[BTB_IDX_BITS:1];
        lk_tag_s      = fetch_pc[15:BTB_IDX_BITS+1];
        lk_pht_idx_s  = ghr_r ^ fetch_pc[GHR_BITS:1];
        up_idx_s      = upd_pc[BTB_IDX_BITS:1];
        up_tag_s      = upd_pc[15:BTB_IDX_BITS+1];
        up_pht_idx_s  = upd_ghr ^ upd_pc[GHR_BITS:1];
        up_ctr_next_s = sat_ctr(pht_r[up_pht_idx_s], upd_taken);
    end

    // Lookup datapath: registered state, optionally overridden by a same-cycle update.
    always_comb begin
        hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        uc_s      = uc_r[lk_idx_s];
        target_s  = target_r[lk_idx_s];
        ctr_msb_s = pht_r[lk_pht_idx_s][1];
`ifdef BP_FWD_EN
        if (upd_valid && upd_taken && (up_idx_s == lk_idx_s) && (up_tag_s == lk_tag_s)) begin
            hit_s    = 1'b1;
            uc_s     = ~upd_cond;
            target_s = upd_target;
        end else begin
            hit_s    = hit_s;
        end
        if (upd_valid && upd_cond && (up_pht_idx_s == lk_pht_idx_s)) begin
            ctr_msb_s = up_ctr_next_s[1];
        end else begin
            ctr_msb_s = ctr_msb_s;
        end
`endif
    end

    assign pred_hit    = hit_s;
    assign pred_uc     = hit_s & uc_s;
    assign pred_taken  = hit_s & (uc_s | ctr_msb_s);
    assign pred_target = target_s;
    assign pred_ghr    = ghr_r;

    assign mispredict       = upd_valid & (upd_pred_taken != upd_taken);
    assign repair_s         = upd_valid & upd_cond & (mispredict | ~upd_pred_hit);
    assign mispredict_count = count_r;

    // BTB storage: taken resolutions overwrite the indexed entry; not-taken keep it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (upd_valid && upd_taken) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= upd_target;
            uc_r[up_idx_s]     <= ~upd_cond;
        end
    end

    // PHT training on resolved conditional branches, indexed by the fetch-time history.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (upd_valid && upd_cond) begin
            pht_r[up_pht_idx_s] <= up_ctr_next_s;
        end
    end

    // Global history: repair from the resolved branch beats speculative shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (repair_s) begin
            ghr_r <= {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (fetch_adv && hit_s && !uc_s) begin
            ghr_r <= {ghr_r[GHR_BITS-2:0], pred_taken};
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'h0000;
        end else if (mispredict && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [15:0] fetch_pc;
    logic        fetch_adv;
    logic        pred_hit;
    logic        pred_uc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic [3:0]  pred_ghr;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_cond;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_hit;
    logic        upd_pred_taken;
    logic [3:0]  upd_ghr;
    logic        mispredict;
    logic [15:0] mispredict_count;

    int checks;
    int errors;

    branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .fetch_adv        (fetch_adv),
        .pred_hit         (pred_hit),
        .pred_uc          (pred_uc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_ghr         (pred_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_cond         (upd_cond),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_hit     (upd_pred_hit),
        .upd_pred_taken   (upd_pred_taken),
        .upd_ghr          (upd_ghr),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_upd();
        upd_valid      = 1'b0;
        upd_pc         = 16'h0000;
        upd_cond       = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = 16'h0000;
        upd_pred_hit   = 1'b0;
        upd_pred_taken = 1'b0;
        upd_ghr        = 4'h0;
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic cond, input logic taken,
                             input logic [15:0] tgt, input logic phit, input logic ptaken,
                             input logic [3:0] ghr);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_cond       = cond;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_pred_hit   = phit;
        upd_pred_taken = ptaken;
        upd_ghr        = ghr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_adv = 1'b0;
        fetch_pc = 16'h0040;
        idle_upd();
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", pred_taken); end
        checks++; if (pred_ghr !== 4'h0) begin errors++; $display("FAIL reset_ghr got %h exp 0", pred_ghr); end
        checks++; if (mispredict_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", mispredict_count); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %b exp 0", mispredict); end
    endtask

    task automatic test_jsr();
        logic exp_same_hit;
`ifdef BP_FWD_EN
        exp_same_hit = 1'b1;
`else
        exp_same_hit = 1'b0;
`endif
        fetch_pc = 16'h0040;
        drive_upd(16'h0040, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 4'h0);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL jsr_mispredict got %b exp 1", mispredict); end
        checks++; if (pred_hit !== exp_same_hit) begin errors++; $display("FAIL jsr_same_cycle_hit got %b exp %b", pred_hit, exp_same_hit); end
        step();
        idle_upd();
        fetch_adv = 1'b1;
        #1;
        checks++; if (mispredict_count !== 16'h0001) begin errors++; $display("FAIL jsr_count got %h exp 0001", mispredict_count); end
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL jsr_hit got %b exp 1", pred_hit); end
        checks++; if (pred_uc !== 1'b1) begin errors++; $display("FAIL jsr_uc got %b exp 1", pred_uc); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jsr_taken got %b exp 1", pred_taken); end
        checks++; if (pred_target !== 16'h1234) begin errors++; $display("FAIL jsr_target got %h exp 1234", pred_target); end
        step();
        fetch_adv = 1'b0;
        #1;
        checks++; if (pred_ghr !== 4'h0) begin errors++; $display("FAIL jsr_ghr_unchanged got %h exp 0", pred_ghr); end
    endtask

    task automatic test_pht_training();
        fetch_pc = 16'h0010;
        // Two correct taken resolutions: PHT[8] 01 -> 10 -> 11, no GHR repair.
        drive_upd(16'h0010, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 4'h0);
        step();
        step();
        idle_upd();
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pht_taken_after_train got %b exp 1", pred_taken); end
        checks++; if (pred_uc !== 1'b0) begin errors++; $display("FAIL pht_uc got %b exp 0", pred_uc); end
        checks++; if (pred_target !== 16'h0100) begin errors++; $display("FAIL pht_target got %h exp 0100", pred_target); end
        // Not-taken once: 11 -> 10, still taken.
        drive_upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
        step();
        idle_upd();
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pht_nt1_taken got %b exp 1", pred_taken); end
        // Not-taken again: 10 -> 01, not taken; entry kept.
        drive_upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
        step();
        idle_upd();
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL pht_nt2_taken got %b exp 0", pred_taken); end
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL pht_nt_entry_kept got %b exp 1", pred_hit); end
        checks++; if (pred_target !== 16'h0100) begin errors++; $display("FAIL pht_nt_target_kept got %h exp 0100", pred_target); end
        // Two more not-taken (01->00->00 saturates), one taken -> 01, still not taken.
        drive_upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
        step();
        step();
        drive_upd(16'h0010, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 4'h0);
        step();
        idle_upd();
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL pht_sat_low got %b exp 0", pred_taken); end
        // Retrain to 11 for the history test.
        drive_upd(16'h0010, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 4'h0);
        step();
        step();
        idle_upd();
        #1;
        checks++; if (mispredict_count !== 16'h0001) begin errors++; $display("FAIL pht_count_held got %h exp 0001", mispredict_count); end
    endtask

    task automatic test_ghr();
        fetch_pc = 16'h0010;
        fetch_adv = 1'b1;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ghr_pre_taken got %b exp 1", pred_taken); end
        step();
        fetch_adv = 1'b0;
        #1;
        checks++; if (pred_ghr !== 4'h1) begin errors++; $display("FAIL ghr_spec_shift got %h exp 1", pred_ghr); end
        // History 0001 hashes fetch 0x0010 to PHT[9], still at its reset value.
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ghr_hash_taken got %b exp 0", pred_taken); end
        step();
        checks++; if (pred_ghr !== 4'h1) begin errors++; $display("FAIL ghr_stall_hold got %h exp 1", pred_ghr); end
        // Mispredicted resolution plus a same-cycle speculative hit: repair wins.
        fetch_adv = 1'b1;
        drive_upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'h0);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ghr_repair_mispredict got %b exp 1", mispredict); end
        step();
        fetch_adv = 1'b0;
        idle_upd();
        #1;
        checks++; if (pred_ghr !== 4'h0) begin errors++; $display("FAIL ghr_repair got %h exp 0", pred_ghr); end
        checks++; if (mispredict_count !== 16'h0002) begin errors++; $display("FAIL ghr_count got %h exp 0002", mispredict_count); end
        // Correct prediction that missed in the BTB still repairs the history.
        drive_upd(16'h0010, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 4'h5);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ghr_miss_mispredict got %b exp 0", mispredict); end
        step();
        idle_upd();
        #1;
        checks++; if (pred_ghr !== 4'hB) begin errors++; $display("FAIL ghr_miss_repair got %h exp b", pred_ghr); end
    endtask

    task automatic test_alias();
        drive_upd(16'h0002, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 4'h0);
        step();
        drive_upd(16'h0012, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 4'h0);
        step();
        idle_upd();
        fetch_pc = 16'h0002;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_old_miss got %b exp 0", pred_hit); end
        checks++; if (pred_target !== 16'h3333) begin errors++; $display("FAIL alias_target_raw got %h exp 3333", pred_target); end
        fetch_pc = 16'h0012;
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %b exp 1", pred_hit); end
        checks++; if (pred_target !== 16'h3333) begin errors++; $display("FAIL alias_new_target got %h exp 3333", pred_target); end
    endtask

    task automatic test_saturation();
        drive_upd(16'h0040, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        idle_upd();
        #1;
        checks++; if (mispredict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h exp ffff", mispredict_count); end
        step();
        checks++; if (mispredict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", mispredict_count); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        fetch_pc = 16'h0010;
        fetch_adv = 1'b1;
        drive_upd(16'h0004, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 4'h3);
        step();
        reset = 1'b0;
        fetch_adv = 1'b0;
        idle_upd();
        fetch_pc = 16'h0004;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rstp_no_write got %b exp 0", pred_hit); end
        checks++; if (mispredict_count !== 16'h0000) begin errors++; $display("FAIL rstp_count got %h exp 0000", mispredict_count); end
        checks++; if (pred_ghr !== 4'h0) begin errors++; $display("FAIL rstp_ghr got %h exp 0", pred_ghr); end
        fetch_pc = 16'h0012;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rstp_btb_cleared got %b exp 0", pred_hit); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        fetch_pc = 16'h0000;
        fetch_adv = 1'b0;
        idle_upd();
        test_reset();
        test_jsr();
        test_pht_training();
        test_ghr();
        test_alias();
        test_saturation();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
